magma_core: RTL and testbench

MAGMA_CORE -- requirements
Module: magma_core

---
 rtl/magma_pkg.sv | 67 ++++++
 rtl/magma_g.sv | 25 ++
 rtl/magma_core.sv | 155 +++++++++++++++
 tb/tb_magma_core.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/magma_pkg.sv
// -----------------------------------------------------------------------------
// magma_pkg
// Shared definitions for the Magma (GOST R 34.12-2015, 64-bit block) core:
//   - FSM state encoding used by magma_core
//   - round count and the g-function rotate amount
//   - the Magma substitution layer (s_box), a 32-bit rotate helper
//   - key-index function giving which 32-bit subkey feeds round i
// No ports; imported by magma_core and magma_g.
// -----------------------------------------------------------------------------
package magma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int MAGMA_ROUNDS = 32;
   localparam int ROT_AMT      = 11;

   // One row per 4-bit S-box Pi0..Pi7. Entry v of a row sits in bits
   // [4*v +: 4], so each hex constant reads as Pi(15) ... Pi(0).
   localparam logic [63:0] SBOX_ROWS [8] = '{
      64'h1F30_7D8E_9B5A_264C,   // Pi0
      64'hF0DB_74E1_C5A9_3286,   // Pi1
      64'h069C_471E_DAF2_853B,   // Pi2
      64'hB9E3_5A07_6F4D_128C,   // Pi3
      64'hC24B_E390_D618_A5F7,   // Pi4
      64'h0E34_187B_AC29_6FD5,   // Pi5
      64'h73AD_0B4F_C196_52E8,   // Pi6
      64'h2BC9_6AF4_3850_DE71    // Pi7
   };

   // Nibble-wise substitution: nibble j (bits [4j+3:4j]) goes through Pi_j.
   function automatic logic [31:0] s_box(input logic [31:0] x);
      logic [31:0] y;
      logic [63:0] row;
      logic [3:0]  nib;
      y = 32'h0000_0000;
      for (int j = 0; j < 8; j++) begin
         row             = SBOX_ROWS[j];
         nib             = x[4*j +: 4];
         y[4*j +: 4]     = row[4*nib +: 4];
      end
      return y;
   endfunction

   // Circular left rotation within 32 bits.
   function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Subkey index for round i. Forward order k0..k7 is used for the first
   // 24 rounds when encrypting and only the first 8 when decrypting; all
   // remaining rounds use the reversed order k7..k0, i.e. 7 - (i mod 8),
   // which is the bitwise complement of the low three bits.
   function automatic logic [2:0] key_idx(input logic [4:0] i, input logic dec);
      logic fwd;
      if (dec) begin
         fwd = (i < 5'd8);
      end else begin
         fwd = (i < 5'd24);
      end
      return fwd ? i[2:0] : ~i[2:0];
   endfunction

endpackage

// File: rtl/magma_g.sv
// -----------------------------------------------------------------------------
// magma_g
// Combinational Magma round function g(x,k) = rotl11(S(x + k mod 2^32)).
// Ports:
//   x_i [31:0]  right half of the block (a0)
//   k_i [31:0]  round subkey
//   y_o [31:0]  g(x_i, k_i)
// -----------------------------------------------------------------------------
module magma_g
   import magma_pkg::*;
(
   input  logic [31:0] x_i,
   input  logic [31:0] k_i,
   output logic [31:0] y_o
);

   logic [31:0] sum_s;
   logic [31:0] sub_s;

   // 32-bit addition wraps naturally modulo 2^32.
   assign sum_s = x_i + k_i;
   assign sub_s = s_box(sum_s);
   assign y_o   = rotl32(sub_s, ROT_AMT);

endmodule

// File: rtl/magma_core.sv
// -----------------------------------------------------------------------------
// magma_core
// Iterative Magma block cipher (64-bit block, 256-bit key), encrypt and
// optionally decrypt, ROUNDS_PER_CLK rounds per clock (1, 2, 4 or 8).
// Parameters:
//   ROUNDS_PER_CLK  unrolled rounds per RUN cycle; must divide 32
//   DEC_EN          1 = imode honoured, 0 = always encrypt
// Ports:
//   iclk            clock, rising edge
//   irst_n          asynchronous active-low reset
//   istart          start request, taken only while oready = 1
//   imode           0 = encrypt, 1 = decrypt (sampled with istart)
//   iblock [63:0]   input block, a1 = [63:32], a0 = [31:0]
//   ikey   [255:0]  key, k0 = [255:224] ... k7 = [31:0]
//   oblock [63:0]   result, held from DONE until the next result
//   odone           one-cycle pulse while oblock carries a new result
//   oready          high in IDLE and DONE
// A start is accepted in IDLE or in the DONE cycle, which allows
// back-to-back operation with no idle gap.
// -----------------------------------------------------------------------------
module magma_core
   import magma_pkg::*;
#(
   parameter int ROUNDS_PER_CLK = 1,
   parameter int DEC_EN         = 1
)(
   input  logic         iclk,
   input  logic         irst_n,
   input  logic         istart,
   input  logic         imode,
   input  logic [63:0]  iblock,
   input  logic [255:0] ikey,
   output logic [63:0]  oblock,
   output logic         odone,
   output logic         oready
);

   localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CLK);
   // Counter value at the start of the cycle that executes round 31.
   localparam logic [4:0] CNT_LAST = 5'(MAGMA_ROUNDS - ROUNDS_PER_CLK);

   state_e         state_q;
   logic [4:0]     cnt_q;
   logic [4:0]     cnt_d;
   logic [63:0]    blk_q;
   logic [63:0]    blk_d;
   logic [255:0]   key_q;
   logic           mode_q;
   logic [63:0]    oblock_q;
   logic           odone_q;
   logic           oready_q;

   logic           accept_s;
   logic           mode_in_s;
   logic [31:0]    k_w [8];

   // oready is only high in IDLE and DONE, so it alone qualifies a start.
   assign accept_s  = istart & oready_q;
   assign mode_in_s = (DEC_EN != 0) ? imode : 1'b0;

   // Split the latched key into its eight 32-bit words, k0 at the top.
   for (genvar j = 0; j < 8; j++) begin : g_key
      assign k_w[j] = key_q[32*(7-j) +: 32];
   end

   // Unrolled round chain, purely combinational within one cycle.
   for (genvar r = 0; r < ROUNDS_PER_CLK; r++) begin : g_round
      logic [63:0] a_in;
      logic [63:0] a_out;
      logic [4:0]  idx;
      logic [2:0]  kidx;
      logic [31:0] g_out;
      logic [31:0] mix;

      if (r == 0) begin : g_first
         assign a_in = blk_q;
      end else begin : g_next
         assign a_in = g_round[r-1].a_out;
      end

      assign idx  = cnt_q + 5'(r);
      assign kidx = key_idx(idx, mode_q);

      magma_g u_g (
         .x_i (a_in[31:0]),
         .k_i (k_w[kidx]),
         .y_o (g_out)
      );

      assign mix = g_out ^ a_in[63:32];
      // Round 31 writes the mixed word into a1 and keeps a0: no swap.
      assign a_out = (idx == 5'd31) ? {mix, a_in[31:0]} : {a_in[31:0], mix};
   end

   assign blk_d = g_round[ROUNDS_PER_CLK-1].a_out;
   assign cnt_d = cnt_q + CNT_STEP;

   // Control FSM together with the datapath and registered outputs.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         blk_q    <= 64'h0;
         key_q    <= 256'h0;
         mode_q   <= 1'b0;
         oblock_q <= 64'h0;
         odone_q  <= 1'b0;
         oready_q <= 1'b1;
      end else if (accept_s) begin
         // Taken from IDLE or from the DONE cycle alike.
         state_q  <= ST_RUN;
         cnt_q    <= 5'd0;
         blk_q    <= iblock;
         key_q    <= ikey;
         mode_q   <= mode_in_s;
         odone_q  <= 1'b0;
         oready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               odone_q  <= 1'b0;
               oready_q <= 1'b1;
            end
            ST_RUN: begin
               blk_q <= blk_d;
               cnt_q <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  state_q  <= ST_DONE;
                  oblock_q <= blk_d;
                  odone_q  <= 1'b1;
                  oready_q <= 1'b1;
               end else begin
                  odone_q  <= 1'b0;
                  oready_q <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q  <= ST_IDLE;
               odone_q  <= 1'b0;
               oready_q <= 1'b1;
            end
            default: begin
               state_q  <= ST_IDLE;
               odone_q  <= 1'b0;
               oready_q <= 1'b1;
            end
         endcase
      end
   end

   assign oblock = oblock_q;
   assign odone  = odone_q;
   assign oready = oready_q;

endmodule

// File: tb/tb_magma_core.sv
// -----------------------------------------------------------------------------
// tb_magma_core
// Drives five magma_core instances (R = 1, 2, 4, 8 and an R = 1 encrypt-only
// build) from shared inputs, with a per-instance start enable, and compares
// results, latency and odone pulse counts against a behavioural Magma model.
// Latency is counted in clock cycles from the accepting edge up to and
// including the DONE cycle.
// -----------------------------------------------------------------------------
module tb_magma_core;

   localparam int NI = 5;
   localparam int RS [NI] = '{1, 2, 4, 8, 1};
   localparam int DE [NI] = '{1, 1, 1, 1, 0};

   localparam logic [255:0] V_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  V_PT  = 64'hfedcba9876543210;
   localparam logic [63:0]  V_CT  = 64'h4ee901e5c2d8ca3d;

   // Magma S-boxes Pi0..Pi7 in natural table order.
   int SB [8][16] = '{
      '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
      '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
      '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
      '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
      '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
      '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
      '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
      '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
   };

   logic          iclk;
   logic          irst_n;
   logic          start;
   logic [NI-1:0] en;
   logic          imode;
   logic [63:0]   iblock;
   logic [255:0]  ikey;
   logic [63:0]   ob   [NI];
   logic          od   [NI];
   logic          ordy [NI];

   int            n_cmp;
   int            n_bad;
   logic [63:0]   res_a    [NI];
   int            lat_a    [NI];
   int            pulses_a [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      magma_core #(
         .ROUNDS_PER_CLK (RS[g]),
         .DEC_EN         (DE[g])
      ) u_dut (
         .iclk   (iclk),
         .irst_n (irst_n),
         .istart (start & en[g]),
         .imode  (imode),
         .iblock (iblock),
         .ikey   (ikey),
         .oblock (ob[g]),
         .odone  (od[g]),
         .oready (ordy[g])
      );
   end

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge iclk);
      #1;
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   // Reference Magma: 32 Feistel rounds, subkey schedule built as a list.
   function automatic logic [63:0] ref_magma(input logic [63:0] blk, input logic [255:0] key, input bit dec);
      logic [31:0] k [8];
      int          ord [32];
      logic [31:0] a1, a0, s, t;
      int          nib;
      bit          rev;
      for (int j = 0; j < 8; j++) k[j] = key[255 - 32*j -: 32];
      for (int i = 0; i < 32; i++) begin
         rev    = dec ? (i / 8 > 0) : (i / 8 == 3);
         ord[i] = rev ? 7 - (i % 8) : i % 8;
      end
      a1 = blk[63:32];
      a0 = blk[31:0];
      for (int i = 0; i < 32; i++) begin
         s = a0 + k[ord[i]];
         t = 32'h0;
         for (int n = 0; n < 8; n++) begin
            nib = int'((s >> (4*n)) & 32'hF);
            t   = t | (32'(SB[n][nib]) << (4*n));
         end
         t = ((t << 11) | (t >> 21)) ^ a1;
         if (i == 31) begin
            a1 = t;
         end else begin
            a1 = a0;
            a0 = t;
         end
      end
      return {a1, a0};
   endfunction

   // One operation on the instances in mask; optional istart poke at cycle poke.
   task automatic run_op(input logic [63:0] blk, input logic [255:0] key, input logic mode,
                         input logic [NI-1:0] mask, input int poke);
      logic [63:0] exp;
      iblock = blk;
      ikey   = key;
      imode  = mode;
      en     = mask;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int j = 0; j < NI; j++) begin
         lat_a[j]    = 0;
         pulses_a[j] = 0;
         res_a[j]    = 64'h0;
      end
      iblock = {$urandom, $urandom};
      ikey   = rand_key();
      imode  = ~mode;
      for (int n = 1; n <= 40; n++) begin
         if (n == poke) start = 1'b1;
         tick();
         start = 1'b0;
         if (n == poke) check_val("ready_in_run", 64'(ordy[0]), 64'd0);
         for (int j = 0; j < NI; j++) begin
            if (mask[j] && od[j]) begin
               pulses_a[j]++;
               if (lat_a[j] == 0) begin
                  lat_a[j] = n + 1;
                  res_a[j] = ob[j];
               end
            end
         end
      end
      for (int j = 0; j < NI; j++) begin
         if (mask[j]) begin
            exp = ref_magma(blk, key, mode && (DE[j] != 0));
            check_val($sformatf("result[%0d]", j), res_a[j], exp);
            check_val($sformatf("latency[%0d]", j), 64'(lat_a[j]), 64'(32 / RS[j] + 1));
            check_val($sformatf("pulses[%0d]", j), 64'(pulses_a[j]), 64'd1);
            check_val($sformatf("hold[%0d]", j), ob[j], exp);
         end
      end
   endtask

   initial begin
      int          t1, t2, np;
      logic [63:0] r1, r2, b1, b2;
      logic [255:0] k1;

      n_cmp  = 0;
      n_bad  = 0;
      irst_n = 1'b0;
      start  = 1'b0;
      en     = '0;
      imode  = 1'b0;
      iblock = 64'h0;
      ikey   = 256'h0;

      // Reset state.
      repeat (3) tick();
      for (int j = 0; j < NI; j++) begin
         check_val($sformatf("rst_oblock[%0d]", j), ob[j], 64'h0);
         check_val($sformatf("rst_odone[%0d]", j), 64'(od[j]), 64'd0);
         check_val($sformatf("rst_oready[%0d]", j), 64'(ordy[j]), 64'd1);
      end
      irst_n = 1'b1;
      tick();

      // Reference vector, encrypt on every build.
      run_op(V_PT, V_KEY, 1'b0, 5'b11111, 0);
      for (int j = 0; j < NI; j++) check_val($sformatf("vec_enc[%0d]", j), res_a[j], V_CT);

      // Reference vector, decrypt (encrypt-only build still encrypts).
      run_op(V_CT, V_KEY, 1'b1, 5'b11111, 0);
      for (int j = 0; j < 4; j++) check_val($sformatf("vec_dec[%0d]", j), res_a[j], V_PT);

      // Random blocks, keys and modes.
      for (int i = 0; i < 8; i++) begin
         run_op({$urandom, $urandom}, rand_key(), 1'($urandom_range(0, 1)), 5'b11111, 0);
      end

      // istart pulsed mid-RUN with another block must be ignored.
      run_op(V_PT, V_KEY, 1'b0, 5'b00001, 10);
      check_val("midrun_const", res_a[0], V_CT);

      // Reset asserted after round 10 aborts without odone.
      iblock = V_PT;
      ikey   = V_KEY;
      imode  = 1'b0;
      en     = 5'b00001;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (10) tick();
      irst_n = 1'b0;
      #1;
      check_val("abort_oblock", ob[0], 64'h0);
      check_val("abort_odone", 64'(od[0]), 64'd0);
      check_val("abort_oready", 64'(ordy[0]), 64'd1);
      np = 0;
      for (int n = 0; n < 40; n++) begin
         if (n == 2) irst_n = 1'b1;
         tick();
         if (od[0]) np++;
      end
      check_val("abort_no_done", 64'(np), 64'd0);
      check_val("abort_oblock_after", ob[0], 64'h0);
      run_op(V_PT, V_KEY, 1'b0, 5'b00001, 0);
      check_val("restart_const", res_a[0], V_CT);

      // istart held through DONE: second op accepted in the DONE cycle.
      b1 = {$urandom, $urandom};
      b2 = {$urandom, $urandom};
      k1 = rand_key();
      iblock = b1;
      ikey   = k1;
      imode  = 1'b0;
      en     = 5'b00001;
      start  = 1'b1;
      tick();
      iblock = b2;
      t1 = 0;
      t2 = 0;
      np = 0;
      r1 = 64'h0;
      r2 = 64'h0;
      for (int n = 1; n <= 80; n++) begin
         tick();
         if (np == 1 && start) begin
            start  = 1'b0;
            iblock = {$urandom, $urandom};
         end
         if (od[0]) begin
            np++;
            if (np == 1) begin
               t1 = n;
               r1 = ob[0];
            end else if (np == 2) begin
               t2 = n;
               r2 = ob[0];
            end
         end
      end
      start = 1'b0;
      check_val("b2b_pulses", 64'(np), 64'd2);
      check_val("b2b_lat1", 64'(t1 + 1), 64'd33);
      check_val("b2b_spacing", 64'(t2 - t1), 64'd33);
      check_val("b2b_res1", r1, ref_magma(b1, k1, 1'b0));
      check_val("b2b_res2", r2, ref_magma(b2, k1, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
